// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode map, sequencer states,
// default PC width and the conditional-branch decision helper.
package fetch_sequencer_pkg;

    localparam int unsigned PC_W = 32;

    // Opcode map shared with the control decoder (instr[31:28]).
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_INC   = 4'b0101;
    localparam logic [3:0] OP_NEG   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_JUMP  = 4'b1000;
    localparam logic [3:0] OP_BRZ   = 4'b1001;
    localparam logic [3:0] OP_JM    = 4'b1010;
    localparam logic [3:0] OP_BRN   = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1110;
    localparam logic [3:0] OP_SVPC  = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_RESOLVE = 2'b10
    } state_e;

    // A conditional branch is taken only for BRZ with Z set or BRN with N set.
    function automatic logic cond_branch_taken(
        input logic [3:0] op,
        input logic       z,
        input logic       n
    );
        case (op)
            OP_BRZ:  return z;
            OP_BRN:  return n;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC selection: jump target, taken conditional branch target, or pc+1
// with natural wrap at the top of the address space.
module next_pc_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = fetch_sequencer_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [3:0]      opcode_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic            jump_mem_i,
    input  logic            z_flag_i,
    input  logic            n_flag_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] pc_inc_s;

    // Sequential successor; the adder drops the carry so all-ones wraps to zero.
    assign pc_inc_s = pc_i + {{(PC_W-1){1'b0}}, 1'b1};

    // Jumps (register or memory target) win over branches; branches need their flag.
    always_comb begin
        next_pc_o = pc_inc_s;
        if (jump_i || jump_mem_i) begin
            next_pc_o = target_i;
        end else if (branch_i && cond_branch_taken(opcode_i, z_flag_i, n_flag_i)) begin
            next_pc_o = target_i;
        end else begin
            next_pc_o = pc_inc_s;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: fetches one instruction word, issues it for one cycle,
// then waits for the execute stage to resolve the next program counter.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned      PC_W     = fetch_sequencer_pkg::PC_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [3:0]      opcode,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            ex_done,
    input  logic            branch,
    input  logic            jump,
    input  logic            jump_mem,
    input  logic            z_flag,
    input  logic            n_flag,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic [PC_W-1:0] next_pc_d;

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .pc_i       (pc_q),
        .opcode_i   (instr_q[31:28]),
        .branch_i   (branch),
        .jump_i     (jump),
        .jump_mem_i (jump_mem),
        .z_flag_i   (z_flag),
        .n_flag_i   (n_flag),
        .target_i   (target),
        .next_pc_o  (next_pc_d)
    );

    // Sequencer FSM; the request is only raised one clock after reset release,
    // and an access is accepted only while the request is actually visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_q && imem_ready) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else begin
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_RESOLVE;
                end
                ST_RESOLVE: begin
                    valid_q <= 1'b0;
                    if (ex_done) begin
                        pc_q    <= next_pc_d;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end else begin
                        req_q   <= 1'b0;
                        state_q <= ST_RESOLVE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:28];
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against a next-pc reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [3:0]  opcode;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        branch;
    logic        jump;
    logic        jump_mem;
    logic        z_flag;
    logic        n_flag;
    logic [31:0] target;
    logic [31:0] pc;

    int total;
    int bad;
    logic [31:0] model_pc;

    fetch_sequencer #(
        .PC_W     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .opcode      (opcode),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .branch      (branch),
        .jump        (jump),
        .jump_mem    (jump_mem),
        .z_flag      (z_flag),
        .n_flag      (n_flag),
        .target      (target),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rule: jumps take the target, BRZ/BRN take it on their flag,
    // everything else moves to the next word modulo 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [3:0] op,
                                             input logic br, input logic jp,
                                             input logic z, input logic n,
                                             input logic [31:0] tgt);
        logic taken;
        logic [32:0] wide;
        taken = jp || (br && ((op == 4'd9 && z) || (op == 4'd11 && n)));
        wide  = ({1'b0, cur} + 33'd1) % 33'h1_0000_0000;
        return taken ? tgt : wide[31:0];
    endfunction

    // Plays one instruction through fetch / issue / resolve and reports what was seen.
    task automatic run_instr(input logic [31:0] rd, input int stall,
                             input logic br, input logic jp, input logic jm,
                             input logic z, input logic n, input logic [31:0] tgt,
                             input int exd, input logic noise,
                             output logic [31:0] addr_seen, output int held_bad,
                             output int vcount, output logic [31:0] instr_seen,
                             output logic [3:0] op_seen, output logic tmo);
        int w;
        tmo = 1'b0; held_bad = 0; vcount = 0; w = 0;
        addr_seen = 32'h0; instr_seen = 32'h0; op_seen = 4'h0;
        while (imem_req !== 1'b1 && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        if (imem_req !== 1'b1) begin
            tmo = 1'b1;
        end else begin
            addr_seen = imem_addr;
            for (int k = 0; k < stall; k++) begin
                imem_ready = 1'b0; ex_done = noise; jump = noise; target = $urandom;
                @(posedge clk); #1;
                if (imem_req !== 1'b1 || imem_addr !== addr_seen) held_bad++;
            end
            ex_done = 1'b0; jump = 1'b0;
            imem_ready = 1'b1; imem_rdata = rd;
            @(posedge clk); #1;
            imem_ready = 1'b0; imem_rdata = $urandom;
            if (instr_valid === 1'b1) vcount++;
            instr_seen = instr; op_seen = opcode;
            ex_done = noise; jump = noise; branch = noise; z_flag = 1'b1; target = $urandom;
            @(posedge clk); #1;
            if (instr_valid === 1'b1) vcount++;
            if (pc !== addr_seen || instr !== instr_seen) held_bad++;
            ex_done = 1'b0; jump = 1'b0; branch = 1'b0;
            for (int k = 0; k < exd; k++) begin
                @(posedge clk); #1;
                if (instr_valid === 1'b1) vcount++;
                if (pc !== addr_seen || instr !== instr_seen || imem_req !== 1'b0) held_bad++;
            end
            branch = br; jump = jp; jump_mem = jm; z_flag = z; n_flag = n; target = tgt;
            ex_done = 1'b1;
            @(posedge clk); #1;
            if (instr_valid === 1'b1) vcount++;
            ex_done = 1'b0; branch = 1'b0; jump = 1'b0; jump_mem = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0;
        branch = 1'b0; jump = 1'b0; jump_mem = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
        target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (opcode !== 4'h0) begin bad++; $display("FAIL rst_opcode got=%h exp=0", opcode); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rel_addr got=%h exp=0", imem_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        logic exp_v, exp_r;
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h4000_0000;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            exp_v = (i % 3 == 2);
            exp_r = (i % 3 == 1);
            total++; if (instr_valid !== exp_v) begin bad++; $display("FAIL seq_valid cyc=%0d got=%b exp=%b", i, instr_valid, exp_v); end
            total++; if (imem_req !== exp_r) begin bad++; $display("FAIL seq_req cyc=%0d got=%b exp=%b", i, imem_req, exp_r); end
            if (exp_r) begin
                total++; if (imem_addr !== 32'((i - 1) / 3)) begin bad++; $display("FAIL seq_addr cyc=%0d got=%h exp=%h", i, imem_addr, 32'((i - 1) / 3)); end
            end
            if (exp_v) begin
                total++; if (opcode !== 4'b0100) begin bad++; $display("FAIL seq_opcode cyc=%0d got=%h exp=4", i, opcode); end
            end
            ex_done = (i % 3 == 0);
        end
        @(posedge clk); #1;
        ex_done = 1'b0; imem_ready = 1'b0;
        model_pc = 32'h3;
    endtask

    task automatic test_stall();
        logic [31:0] a, ins; int hb, vc; logic [3:0] op; logic to;
        run_instr(32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (to !== 1'b0 || a !== 32'h3) begin bad++; $display("FAIL stall_pre_addr got=%h exp=3 tmo=%b", a, to); end
        run_instr(32'h0000_0000, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b1, a, hb, vc, ins, op, to);
        total++; if (to !== 1'b0 || a !== 32'h5) begin bad++; $display("FAIL stall_addr got=%h exp=5 tmo=%b", a, to); end
        total++; if (hb !== 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", hb); end
        total++; if (vc !== 1) begin bad++; $display("FAIL stall_pulses got=%0d exp=1", vc); end
    endtask

    task automatic test_branches();
        logic [31:0] a, ins; int hb, vc; logic [3:0] op; logic to;
        run_instr(32'h9000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h6 || op !== 4'b1001) begin bad++; $display("FAIL brz_taken_at got=%h/%h exp=6/9", a, op); end
        run_instr(32'h9000_0000, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h20) begin bad++; $display("FAIL brz_taken got=%h exp=20", a); end
        run_instr(32'hB000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h21) begin bad++; $display("FAIL brz_not_taken got=%h exp=21", a); end
        run_instr(32'hB000_0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 2, 1'b1, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h22) begin bad++; $display("FAIL brn_not_taken got=%h exp=22", a); end
        total++; if (hb !== 0 || vc !== 1) begin bad++; $display("FAIL brn_hold got=%0d/%0d exp=0/1", hb, vc); end
    endtask

    task automatic test_jm_wrap();
        logic [31:0] a, ins; int hb, vc; logic [3:0] op; logic to;
        run_instr(32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h40) begin bad++; $display("FAIL brn_taken got=%h exp=40", a); end
        run_instr(32'hA000_0000, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'hFFFF_FFFF || op !== 4'b1010) begin bad++; $display("FAIL jm_at got=%h/%h exp=ffffffff/a", a, op); end
        run_instr(32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h99) begin bad++; $display("FAIL jm_target got=%h exp=99", a); end
        run_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'hFFFF_FFFF) begin bad++; $display("FAIL nop_top got=%h exp=ffffffff", a); end
        run_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (a !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", a); end
    endtask

    task automatic test_reset_mid_resolve();
        logic [31:0] a, ins; int hb, vc; logic [3:0] op; logic to; int w;
        w = 0;
        while (imem_req !== 1'b1 && w < 8) begin @(posedge clk); #1; w++; end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_wait got=%b exp=1", imem_req); end
        imem_ready = 1'b1; imem_rdata = 32'h5000_0000;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        ex_done = 1'b1; jump = 1'b1; target = 32'h77;
        #1 rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b exp=0", imem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_pc got=%h exp=0", pc); end
        total++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mid_instr got=%h/%b exp=0/0", instr, instr_valid); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; ex_done = 1'b0; jump = 1'b0;
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mid_restart got=%b/%h/%b exp=1/0/0", imem_req, imem_addr, instr_valid); end
        run_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, a, hb, vc, ins, op, to);
        total++; if (to !== 1'b0 || a !== 32'h0) begin bad++; $display("FAIL mid_refetch got=%h exp=0", a); end
        model_pc = 32'h1;
    endtask

    task automatic test_random();
        logic [31:0] a, ins, rd, tgt; int hb, vc; logic [3:0] op, rop; logic to;
        logic br, jp, jm, z, n; int st, exd;
        for (int it = 0; it < 40; it++) begin
            rop = 4'($urandom_range(0, 15));
            rd  = {rop, 28'($urandom)};
            st  = $urandom_range(0, 3);
            exd = $urandom_range(0, 2);
            jp  = ($urandom_range(0, 3) == 0);
            jm  = jp & 1'($urandom);
            br  = 1'($urandom);
            z   = 1'($urandom);
            n   = 1'($urandom);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_instr(rd, st, br, jp, jm, z, n, tgt, exd, 1'($urandom), a, hb, vc, ins, op, to);
            total++; if (to !== 1'b0 || a !== model_pc) begin bad++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, a, model_pc); end
            total++; if (ins !== rd || op !== rop) begin bad++; $display("FAIL rnd_instr it=%0d got=%h exp=%h", it, ins, rd); end
            total++; if (vc !== 1 || hb !== 0) begin bad++; $display("FAIL rnd_pulse it=%0d got=%0d/%0d exp=1/0", it, vc, hb); end
            model_pc = ref_next(model_pc, rop, br, jp, z, n, tgt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_pc = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branches();
        test_jm_wrap();
        test_reset_mid_resolve();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
